// File: rtl/bsk_bus_sched.sv
// BSK backplane bus master: polls two command boards at a fixed rate and
// serves host register writes with priority, one bus transaction at a time.
module bsk_bus_sched #(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned HOLD_CYC   = 1,
   parameter int unsigned POLL_DIV   = 1000,
   parameter logic [3:0]  CS_A       = 4'b1011,
   parameter logic [3:0]  CS_B       = 4'b1001,
   parameter logic [3:0]  CS_IDLE    = 4'b1111
) (
   input  logic        clk,
   input  logic        iRes,
   input  logic        iWrReq,
   input  logic        iWrSel,
   input  logic [1:0]  iWrAddr,
   input  logic [15:0] iWrData,
   output logic        oWrAck,
   output logic [3:0]  oCS,
   output logic [1:0]  oA,
   output logic        oRd,
   output logic        oWr,
   output logic        oDataOe,
   output logic [15:0] oData,
   input  logic [15:0] iData,
   output logic        oPollVld,
   output logic        oPollSel,
   output logic        oPollAddr,
   output logic [15:0] oPollData,
   output logic        oPollMiss,
   output logic        oBusy
);

   localparam int unsigned         TIMER_W     = $clog2(POLL_DIV);
   localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(POLL_DIV - 1);
   localparam logic [3:0]          SETUP_LAST  = 4'(SETUP_CYC - 1);
   localparam logic [3:0]          STROBE_LAST = 4'(STROBE_CYC - 1);
   localparam logic [3:0]          HOLD_LAST   = 4'(HOLD_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [1:0]           idx_q, idx_d;
   logic                 round_pend_q, round_pend_d;
   logic                 is_wr_q, is_wr_d;
   logic [3:0]           cs_q, cs_d;
   logic [1:0]           a_q, a_d;
   logic                 rd_q, rd_d;
   logic                 wr_q, wr_d;
   logic                 data_oe_q, data_oe_d;
   logic [15:0]          data_q, data_d;
   logic                 wr_ack_q, wr_ack_d;
   logic                 poll_vld_q, poll_vld_d;
   logic                 poll_sel_q, poll_sel_d;
   logic                 poll_addr_q, poll_addr_d;
   logic [15:0]          poll_data_q, poll_data_d;
   logic                 poll_miss_q, poll_miss_d;
   logic                 wrap;
   logic                 round_done;

   always_comb begin
      // NOTE: every *_d gets a default first so no path through the case infers a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      round_pend_d = round_pend_q;
      is_wr_d      = is_wr_q;
      cs_d         = cs_q;
      a_d          = a_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      data_oe_d    = data_oe_q;
      data_d       = data_q;
      wr_ack_d     = 1'b0;
      poll_vld_d   = 1'b0;
      poll_sel_d   = poll_sel_q;
      poll_addr_d  = poll_addr_q;
      poll_data_d  = poll_data_q;
      poll_miss_d  = 1'b0;
      round_done   = 1'b0;

      wrap    = (timer_q == TIMER_LAST);
      timer_d = wrap ? '0 : timer_q + 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            // The ack cycle grants nothing, so a held request re-arms one cycle later.
            if (!wr_ack_q) begin
               if (iWrReq) begin
                  state_d   = ST_SETUP;
                  cnt_d     = '0;
                  is_wr_d   = 1'b1;
                  cs_d      = iWrSel ? CS_B : CS_A;
                  a_d       = iWrAddr;
                  data_d    = iWrData;
                  data_oe_d = 1'b1;
               end else if (round_pend_q) begin
                  state_d = ST_SETUP;
                  cnt_d   = '0;
                  is_wr_d = 1'b0;
                  cs_d    = idx_q[1] ? CS_B : CS_A;
                  a_d     = {1'b0, idx_q[0]};
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = ST_STROBE;
               cnt_d   = '0;
               rd_d    = is_wr_q;
               wr_d    = !is_wr_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == STROBE_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               rd_d    = 1'b1;
               wr_d    = 1'b1;
               if (!is_wr_q) begin
                  poll_vld_d  = 1'b1;
                  poll_data_d = iData;
                  poll_sel_d  = idx_q[1];
                  poll_addr_d = idx_q[0];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               cs_d      = CS_IDLE;
               data_oe_d = 1'b0;
               if (is_wr_q) begin
                  wr_ack_d = 1'b1;
               end else begin
                  idx_d      = idx_q + 2'd1;
                  round_done = (idx_q == 2'd3);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A round finishing on the wrap edge frees the slot for the new round.
      if (round_done) round_pend_d = 1'b0;
      if (wrap) begin
         poll_miss_d  = round_pend_q && !round_done;
         round_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge iRes) begin
      if (iRes) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         timer_q      <= '0;
         idx_q        <= '0;
         round_pend_q <= 1'b0;
         is_wr_q      <= 1'b0;
         cs_q         <= CS_IDLE;
         a_q          <= '0;
         rd_q         <= 1'b1;
         wr_q         <= 1'b1;
         data_oe_q    <= 1'b0;
         data_q       <= '0;
         wr_ack_q     <= 1'b0;
         poll_vld_q   <= 1'b0;
         poll_sel_q   <= 1'b0;
         poll_addr_q  <= 1'b0;
         poll_data_q  <= '0;
         poll_miss_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
         idx_q        <= idx_d;
         round_pend_q <= round_pend_d;
         is_wr_q      <= is_wr_d;
         cs_q         <= cs_d;
         a_q          <= a_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         data_oe_q    <= data_oe_d;
         data_q       <= data_d;
         wr_ack_q     <= wr_ack_d;
         poll_vld_q   <= poll_vld_d;
         poll_sel_q   <= poll_sel_d;
         poll_addr_q  <= poll_addr_d;
         poll_data_q  <= poll_data_d;
         poll_miss_q  <= poll_miss_d;
      end
   end

   assign oWrAck    = wr_ack_q;
   assign oCS       = cs_q;
   assign oA        = a_q;
   assign oRd       = rd_q;
   assign oWr       = wr_q;
   assign oDataOe   = data_oe_q;
   assign oData     = data_q;
   assign oPollVld  = poll_vld_q;
   assign oPollSel  = poll_sel_q;
   assign oPollAddr = poll_addr_q;
   assign oPollData = poll_data_q;
   assign oPollMiss = poll_miss_q;
   assign oBusy     = (state_q != ST_IDLE);

endmodule

// File: doc/bsk_bus_sched.md
Name: bsk_bus_sched

Overview:
Bus-master sequencer for the BSK backplane parallel bus (bD, iRd/iWr active-0, iA[1:0], 4-bit CS code).
- Polls the command registers (addr 00, 01) of two command boards, one per CS code, at a fixed rate.
- Serves host register writes (addr 10 indication, addr 11 control/test_en) with priority over polling.
- Sits between the host-side control logic and the backplane pins; one transaction is on the bus at a time.

Parameters:
SETUP_CYC, 2, clk cycles with CS/A valid before strobe falls (1..15)
STROBE_CYC, 4, clk cycles strobe held low (1..15)
HOLD_CYC, 1, clk cycles CS/A/data held after strobe rises (1..15)
POLL_DIV, 1000, clk cycles between poll-round starts (>=64)
CS_A, 4'b1011, CS code of board 0 (channels 16..01)
CS_B, 4'b1001, CS code of board 1 (channels 32..17)
CS_IDLE, 4'b1111, CS code selecting no board

Ports:
clk  in  1  system clock; all logic on rising edge
iRes  in  1  asynchronous reset, active-high
iWrReq  in  1  host write request; held high until oWrAck
iWrSel  in  1  target board: 0 = CS_A, 1 = CS_B
iWrAddr  in  2  target register address
iWrData  in  16  write data
oWrAck  out  1  one-cycle pulse when write transaction completes
oCS  out  4  bus CS code
oA  out  2  bus address
oRd  out  1  bus read strobe, active 0
oWr  out  1  bus write strobe, active 0
oDataOe  out  1  1 = drive oData onto bD
oData  out  16  write data to bD
iData  in  16  bD as seen by master
oPollVld  out  1  one-cycle pulse, poll word valid
oPollSel  out  1  board of poll word
oPollAddr  out  1  register of poll word (0 = addr 00, 1 = addr 01)
oPollData  out  16  captured raw poll word
oPollMiss  out  1  one-cycle pulse, poll tick while round still running
oBusy  out  1  transaction in progress (state != IDLE)

Behaviour:
- Reset, asynchronous: oCS=CS_IDLE, oA=0, oRd=1, oWr=1, oDataOe=0, oData=0. All pulses 0, oBusy=0, timer=0, poll index=0, round_pend=0.
- Reset mid-transaction: strobe releases immediately; the transaction is lost and not acked.
- All outputs are registered.
- Poll timer counts 0..POLL_DIV-1 and wraps. On wrap, round_pend=1. If round_pend is already 1 at wrap, oPollMiss pulses and no second round is queued.
- Poll round: 4 reads in order idx0 (A, 00), idx1 (A, 01), idx2 (B, 00), idx3 (B, 01). After idx3, round_pend=0 and idx=0.
- Arbitration, evaluated only in IDLE: iWrReq beats a pending poll read. A write between poll reads does not reset idx; the round resumes at the next index.
- FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Grant decided in IDLE cycle t.
- SETUP: cycles t+1 .. t+SETUP_CYC. oCS/oA valid. For writes, oDataOe=1 and oData=latched data.
- STROBE: next STROBE_CYC cycles. oRd=0 (read) or oWr=0 (write).
- HOLD: next HOLD_CYC cycles. Strobe=1; CS/A/data unchanged.
- Return to IDLE: next cycle oCS=CS_IDLE, oDataOe=0, oA holds its last value.
- Minimum one IDLE cycle between transactions, so with defaults back-to-back accesses start every 8 cycles.
- Read capture: iData is sampled on the edge ending the last STROBE cycle. oPollVld pulses in the first HOLD cycle, with oPollData/Sel/Addr held until the next capture.
- Write: iWrSel/iWrAddr/iWrData are latched at grant. oWrAck pulses in the IDLE-return cycle. iWrReq still high in that cycle is ignored (ack cycle), so a new request needs a deasserted-then-asserted or held-after-ack edge one cycle later.
- oRd and oWr are never 0 simultaneously. oDataOe=1 only during write SETUP/STROBE/HOLD.

Test Plan:
- Reset: iRes=1 mid-STROBE of a read -> same cycle oRd=1, oCS=4'b1111, oDataOe=0; after release, no oPollVld until next timer wrap.
- Poll round (POLL_DIV=64): slave returns 16'hC3E1 (A,00), 16'hE1C3 (A,01), 16'h0F0F (B,00), 16'hF0F0 (B,01) -> 4 oPollVld pulses, in that order, with matching Sel/Addr; oRd low exactly 4 cycles each, 8 cycles start-to-start.
- Write: iWrReq, Sel=0, Addr=2'b10, Data=16'h9231 -> oCS=4'b1011, oA=2'b10 with oDataOe=1 two cycles before oWr=0; oWr low 4 cycles; oWrAck pulse 1 cycle after HOLD; oRd stays 1.
- Priority: iWrReq (Sel=1, Addr=2'b11, Data=16'h0001) raised during poll idx1 -> idx1 completes, write runs next with oCS=4'b1001, then idx2 and idx3 follow; 4 poll pulses total.
- Overrun: POLL_DIV=64, continuous iWrReq back-to-back for 200 cycles -> oPollMiss pulses at each wrap while round_pend=1; polling resumes once iWrReq drops.
- Timing params SETUP=1, STROBE=1, HOLD=1 -> read transaction 3 bus cycles, iData sampled correctly when changed one cycle after strobe rises.
